// File: rtl/cordic_vectoring_if.sv
// Handshake and data bundle for the CORDIC vectoring engine.
// Master drives the request; slave returns the status and results.
interface cordic_vectoring_if;
  logic        start;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic        busy;
  logic        out_valid;
  logic [7:0]  angle_out;
  logic [10:0] mag_out;

  modport master (
    output start, x_in, y_in,
    input  busy, out_valid, angle_out, mag_out
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, out_valid, angle_out, mag_out
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative 8-step CORDIC vectoring: rotates (x,y) onto the +x axis and reports angle and unscaled magnitude.
// Latency: 9 cycles from accepted start to out_valid; start is ignored while busy, one conversion in flight.
module cordic_vectoring (
  input  logic            clk,
  input  logic            rst,
  cordic_vectoring_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         iter;
  logic               accept;
  logic               last_iter;

  logic signed [10:0] x, y;
  logic signed [10:0] x_nxt, y_nxt;
  logic signed [10:0] x_shr, y_shr;
  logic signed [10:0] x_ext, y_ext;
  logic [7:0]         z, z_nxt;
  logic [7:0]         atan_val;

  logic               busy_q;
  logic               out_valid_q;
  logic [7:0]         angle_q;
  logic [10:0]        mag_q;

  assign last_iter = (iter == 3'd7);

  // Arctangent table in binary-angle units (128 = pi)
  always_comb begin
    atan_val = 8'd0;
    case (iter)
      3'd0: atan_val = 8'd32;
      3'd1: atan_val = 8'd19;
      3'd2: atan_val = 8'd10;
      3'd3: atan_val = 8'd5;
      3'd4: atan_val = 8'd3;
      3'd5: atan_val = 8'd1;
      3'd6: atan_val = 8'd1;
      3'd7: atan_val = 8'd0;
    endcase
  end

  assign x_ext = {{3{io.x_in[7]}}, io.x_in};
  assign y_ext = {{3{io.y_in[7]}}, io.y_in};

  assign x_shr = x >>> iter;
  assign y_shr = y >>> iter;

  // Rotate toward y = 0 using the old x and y together
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!y[10]) begin
      x_nxt = x + y_shr;
      y_nxt = y - x_shr;
      z_nxt = z + atan_val;
    end else begin
      x_nxt = x - y_shr;
      y_nxt = y + x_shr;
      z_nxt = z - atan_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) begin
          state_nxt = ITER;
          accept    = 1'b1;
        end
      end
      ITER: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter        <= 3'd0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      angle_q     <= '0;
      mag_q       <= '0;
    end else begin
      busy_q      <= (state_nxt != IDLE);
      out_valid_q <= (state == ITER) && last_iter;

      if (accept) begin
        iter <= 3'd0;
        // Left half-plane inputs are pre-rotated by pi so the iterations converge
        if (io.x_in[7]) begin
          x <= -x_ext;
          y <= -y_ext;
          z <= 8'h80;
        end else begin
          x <= x_ext;
          y <= y_ext;
          z <= 8'h00;
        end
      end else if (state == ITER) begin
        iter <= iter + 3'd1;
        x    <= x_nxt;
        y    <= y_nxt;
        z    <= z_nxt;
        if (last_iter) begin
          angle_q <= z_nxt;
          mag_q   <= $unsigned(x_nxt);
        end
      end
    end
  end

  assign io.busy      = busy_q;
  assign io.out_valid = out_valid_q;
  assign io.angle_out = angle_q;
  assign io.mag_out   = mag_q;

endmodule

// File: doc/cordic_vectoring.md
CORDIC_VECTORING -- requirements
Module: cordic_vectoring

Interface
REQ-001 The block SHALL use a single clock, clk; reset is asynchronous and active-low, rst.
REQ-002 Ports SHALL be as follows, one per line, in the form name  direction  width  meaning:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request to begin a conversion; sampled only in IDLE.
- x_in  in  8  signed x coordinate; captured when start is accepted.
- y_in  in  8  signed y coordinate; captured when start is accepted.
- busy  out  1  high whenever state is not IDLE.
- out_valid  out  1  one-cycle pulse marking valid results.
- angle_out  out  8  signed binary angle: 128 = pi, wraps modulo 256.
- mag_out  out  11  unsigned final x; CORDIC gain (~1.647) is not compensated.

Function
REQ-003 The FSM SHALL have three states: IDLE, ITER and DONE.
- IDLE -> ITER on start=1.
- ITER -> DONE after iteration 7.
- DONE -> IDLE unconditionally after one cycle.
REQ-004 On the edge that accepts start, the block SHALL load its registers and clear the iteration counter to 0. Registers are x, y (11-bit signed, sign-extended from the inputs) and z (8-bit).
- If x_in < 0: x = -x_in, y = -y_in, z = 8'h80 (-128).
- Otherwise: x = x_in, y = y_in, z = 0.
REQ-005 Each ITER cycle SHALL perform one iteration i (0..7) using the old x and y simultaneously. ">>>" denotes arithmetic right shift (floor).
- If y >= 0: x += y>>>i; y -= x>>>i; z += atan[i].
- If y < 0: x -= y>>>i; y += x>>>i; z -= atan[i].
REQ-006 The atan LUT SHALL be {32, 19, 10, 5, 3, 1, 1, 0} for i = 0..7.
REQ-007 z SHALL wrap modulo 256. x and y SHALL NOT overflow for any 8-bit input; 11 bits is sufficient.
REQ-008 Latency: with start accepted at edge k, iterations SHALL occur at edges k+1..k+8. The DONE state and out_valid=1 SHALL be visible in the cycle after edge k+8. The FSM SHALL return to IDLE at edge k+9.
REQ-009 angle_out and mag_out SHALL update at edge k+8 and hold until the next completed conversion.
REQ-010 start SHALL be ignored while busy=1, including in DONE. Inputs are not re-captured.
REQ-011 The earliest back-to-back start SHALL be accepted at edge k+9 + 1, i.e. the first edge in IDLE. There SHALL be no pipelining and only one conversion in flight.
REQ-012 busy SHALL equal (state != IDLE) and SHALL be registered.
REQ-013 out_valid SHALL be high for exactly one cycle per accepted start.
REQ-014 Inputs x=0, y=0 SHALL complete normally; the y>=0 branch is taken at every step.
REQ-015 Input x_in = -128 SHALL pre-rotate to x = +128 without overflow.

Reset
REQ-016 While rst=0, asynchronously, the block SHALL force:
- state = IDLE, iteration counter = 0;
- x, y, z = 0;
- busy = 0, out_valid = 0;
- angle_out = 0, mag_out = 0.
REQ-017 Reset asserted mid-conversion SHALL abort the conversion with no out_valid pulse. The first start after rst rises SHALL behave exactly as after power-up.
REQ-018 start SHALL NOT be accepted on the first rising edge at which rst is low. It SHALL be accepted on any rising edge with rst=1 in IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- x=100, y=0, start pulse -> out_valid 9 cycles after accept; angle_out=1, mag_out=166; busy high for 9 cycles.
- x=-100, y=0 -> angle_out=-127 (8'h81), mag_out=166.
- x=0, y=100 -> angle_out within 64±2, mag_out within 164±3.
- start held high continuously with x=100, y=0 -> one conversion per 10 cycles; inputs changed mid-conversion do not affect the result; exactly one out_valid per conversion.
- rst pulsed low at iteration 4 -> busy=0, out_valid=0, outputs 0 immediately; a following start with x=100, y=0 gives angle_out=1, mag_out=166.
- x=-128, y=-128 -> angle_out within -96±2, mag_out within 298±4, no overflow.
